// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared states, response codes and select-width helper for the APB master.
package apb_master_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

    typedef enum logic [1:0] {STS_OKAY, STS_SLVERR, STS_DECERR, STS_TIMEOUT} apb_status_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps the top address bits to a slave index and flags unmapped slots.
module apb_addr_decode import apb_master_pkg::*; #(
    parameter int AW = 9,
    parameter int NUM_SLV = 2,
    localparam int SELW = sel_w(NUM_SLV)
) (
    input  logic [AW-1:0]   addr,
    output logic [SELW-1:0] idx,
    output logic            dec_err
);

    assign idx     = addr[AW-1 -: SELW];
    assign dec_err = int'(idx) >= NUM_SLV;

endmodule

// File: rtl/apb_master_nslv.sv
// apb_master_nslv: request/response to APB3 bridge for NUM_SLV slaves with
// address decode, wait states, slave errors and a wait-state timeout.
module apb_master_nslv import apb_master_pkg::*; #(
    parameter int AW = 9,
    parameter int DW = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [DW-1:0]         req_wdata,
    output logic                  rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic [1:0]            rsp_status,
    output logic [AW-1:0]         PADDR,
    output logic [NUM_SLV-1:0]    PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DW-1:0]         PWDATA,
    input  logic [NUM_SLV*DW-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]    PREADY,
    input  logic [NUM_SLV-1:0]    PSLVERR
);

    localparam int SELW = sel_w(NUM_SLV);
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e      state, state_n;
    apb_status_e     status_q, status_n;
    logic [SELW-1:0] idx_q, dec_idx;
    logic            dec_err;
    logic [CW-1:0]   cnt, cnt_inc;
    logic            sel_ready, sel_err, accept;
    logic [DW-1:0]   sel_rdata;

    apb_addr_decode #(.AW(AW), .NUM_SLV(NUM_SLV)) u_dec (
        .addr    (req_addr),
        .idx     (dec_idx),
        .dec_err (dec_err)
    );

    assign accept    = (state == IDLE) && req_valid;
    assign sel_ready = PREADY[idx_q];
    assign sel_err   = PSLVERR[idx_q];
    assign sel_rdata = PRDATA[int'(idx_q)*DW +: DW];
    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n  = state;
        status_n = status_q;
        case (state)
            IDLE: if (req_valid) begin
                state_n  = dec_err ? RESP : SETUP;
                status_n = dec_err ? STS_DECERR : STS_OKAY;
            end
            SETUP: state_n = ACCESS;
            ACCESS: if (sel_ready) begin
                state_n  = RESP;
                status_n = sel_err ? STS_SLVERR : STS_OKAY;
            end else if (TIMEOUT != 0 && int'(cnt_inc) == TIMEOUT) begin
                state_n  = RESP;
                status_n = STS_TIMEOUT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            status_q  <= STS_OKAY;
            idx_q     <= '0;
            cnt       <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
        end else begin
            state    <= state_n;
            status_q <= status_n;
            cnt      <= accept ? '0 : (state == ACCESS && !sel_ready) ? cnt_inc : cnt;
            // a decode error never reaches the bus, so the bus keeps its previous address
            if (accept && !dec_err) begin
                idx_q  <= dec_idx;
                PADDR  <= req_addr;
                PWRITE <= req_write;
                PWDATA <= req_wdata;
            end
            if (accept)
                rsp_rdata <= '0;
            else if (state == ACCESS && sel_ready && !sel_err && !PWRITE)
                rsp_rdata <= sel_rdata;
        end
    end

    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NUM_SLV; i++)
            PSEL[i] = (state == SETUP || state == ACCESS) && int'(idx_q) == i;
    end

    assign PENABLE    = state == ACCESS;
    assign req_ready  = state == IDLE;
    assign rsp_valid  = state == RESP;
    assign rsp_status = status_q;

    a_paddr_known: assert property (@(posedge PCLK) disable iff (!PRESETn)
        (|PSEL) |-> !$isunknown(PADDR));
    a_psel_onehot: assert property (@(posedge PCLK) disable iff (!PRESETn)
        $onehot0(PSEL));
    a_penable_after_setup: assert property (@(posedge PCLK) disable iff (!PRESETn)
        $rose(PENABLE) |-> $past(state == SETUP));

endmodule

// File: tb/tb_apb_master_nslv.sv
// tb_apb_master_nslv: directed transfers on three parameter variants with a
// response scoreboard fed by the stimulus and drained by a monitor.
module tb_apb_master_nslv;

    logic PCLK = 1'b0, PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    logic [2:0]  rv = '0, rr, rspv, pen, pwr;
    logic        rw = 1'b0;
    logic [8:0]  ra = '0;
    logic [7:0]  wd = '0;
    logic [7:0]  rd [3];
    logic [1:0]  st [3];
    logic [8:0]  pa [3];
    logic [7:0]  pw [3];
    logic [1:0]  psel0, psel2;
    logic [2:0]  psel1;
    logic [23:0] prdata = '0;
    logic [2:0]  pready = '0, pslverr = '0;

    apb_master_nslv u0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_write(rw), .req_addr(ra), .req_wdata(wd), .rsp_valid(rspv[0]),
        .rsp_rdata(rd[0]), .rsp_status(st[0]), .PADDR(pa[0]), .PSEL(psel0),
        .PENABLE(pen[0]), .PWRITE(pwr[0]), .PWDATA(pw[0]), .PRDATA(prdata[15:0]),
        .PREADY(pready[1:0]), .PSLVERR(pslverr[1:0])
    );

    apb_master_nslv #(.NUM_SLV(3)) u1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_write(rw), .req_addr(ra), .req_wdata(wd), .rsp_valid(rspv[1]),
        .rsp_rdata(rd[1]), .rsp_status(st[1]), .PADDR(pa[1]), .PSEL(psel1),
        .PENABLE(pen[1]), .PWRITE(pwr[1]), .PWDATA(pw[1]), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_master_nslv #(.TIMEOUT(0)) u2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(rv[2]), .req_ready(rr[2]),
        .req_write(rw), .req_addr(ra), .req_wdata(wd), .rsp_valid(rspv[2]),
        .rsp_rdata(rd[2]), .rsp_status(st[2]), .PADDR(pa[2]), .PSEL(psel2),
        .PENABLE(pen[2]), .PWRITE(pwr[2]), .PWDATA(pw[2]), .PRDATA(prdata[15:0]),
        .PREADY(pready[1:0]), .PSLVERR(pslverr[1:0])
    );

    int n_vec = 0, n_err = 0, cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp_v, cyc);
        end
    endtask

    function automatic logic [2:0] psel_of(input int d);
        return (d == 1) ? psel1 : (d == 0) ? {1'b0, psel0} : {1'b0, psel2};
    endfunction

    // Slave model: the target slave readies after sl_wait ACCESS cycles; every
    // other slave is permanently ready with an error and garbage data.
    int sl_d = 0, sl_idx = 0, sl_wait = 0, acnt = 0;
    logic sl_err = 1'b0;
    logic [7:0] sl_rd = '0;
    logic [2:0] sel_m;
    always @(negedge PCLK) begin
        sel_m = 3'b001 << sl_idx;
        prdata = 24'hEEEEEE;
        prdata[sl_idx*8 +: 8] = sl_rd;
        if (pen[sl_d]) begin
            pready  = ((acnt >= sl_wait) ? sel_m : 3'b000) | ~sel_m;
            pslverr = ~sel_m | (sl_err ? sel_m : 3'b000);
            acnt++;
        end else begin
            pready  = '0;
            pslverr = '0;
            acnt    = 0;
        end
    end

    typedef struct {
        int d;
        logic [1:0] st;
        logic [7:0] rd;
        int lat;
        int acc;
    } exp_t;
    exp_t q[$];
    exp_t e;

    always @(negedge PCLK) begin
        if (|rspv) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rspv), 32'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_dut", 32'(rspv), 32'(3'b001 << e.d));
                chk("rsp_status", 32'(st[e.d]), 32'(e.st));
                chk("rsp_rdata", 32'(rd[e.d]), 32'(e.rd));
                chk("rsp_latency", cyc - e.acc, e.lat);
                chk("rsp_bus_idle", 32'({psel_of(e.d), pen[e.d]}), 32'd0);
            end
        end
    end

    task automatic xfer(input int d, input logic w, input logic [8:0] a, input logic [7:0] data,
                        input int idx, input int wt, input logic err, input logic [7:0] srd,
                        input logic [1:0] est, input logic [7:0] erd, input int lat);
        @(negedge PCLK);
        sl_d = d; sl_idx = idx; sl_wait = wt; sl_err = err; sl_rd = srd;
        rv = 3'b001 << d; rw = w; ra = a; wd = data;
        chk("req_ready_idle", 32'(rr[d]), 32'd1);
        @(posedge PCLK);
        #1;
        q.push_back('{d, est, erd, lat, cyc - 1});
        rv = '0; rw = ~w; ra = ~a; wd = ~data;
        @(negedge PCLK);
        if (est != 2'b10) begin
            chk("setup_psel", 32'(psel_of(d)), 32'(3'b001 << idx));
            chk("setup_penable", 32'(pen[d]), 32'd0);
            chk("paddr", 32'(pa[d]), 32'(a));
            chk("pwrite", 32'(pwr[d]), 32'(w));
            if (w) chk("pwdata", 32'(pw[d]), 32'(data));
            @(negedge PCLK);
            chk("access_psel_pen", 32'({psel_of(d), pen[d]}), 32'({3'b001 << idx, 1'b1}));
        end else begin
            chk("decerr_psel", 32'(psel_of(d)), 32'd0);
        end
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge PCLK);
        if (q.size() != 0) begin
            chk("rsp_wait_expired", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge PCLK);
        chk("req_ready_after", 32'(rr[d]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("rst_bus", 32'({psel_of(d), pen[d], pwr[d], pa[d], pw[d]}), 32'd0);
            chk("rst_rsp", 32'({rspv[d], rd[d], st[d]}), 32'd0);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk("rst_release_ready", 32'(rr), 32'h7);
        xfer(0, 1'b1, 9'h123, 8'h5A, 1, 0,    1'b0, 8'h00, 2'b00, 8'h00, 3);
        xfer(0, 1'b0, 9'h045, 8'h00, 0, 3,    1'b0, 8'hC3, 2'b00, 8'hC3, 6);
        xfer(0, 1'b1, 9'h1F0, 8'h11, 1, 0,    1'b1, 8'h00, 2'b01, 8'h00, 3);
        xfer(0, 1'b0, 9'h001, 8'h00, 0, 0,    1'b1, 8'hC3, 2'b01, 8'h00, 3);
        xfer(0, 1'b0, 9'h0FF, 8'h00, 0, 1000, 1'b0, 8'h99, 2'b11, 8'h00, 18);
        xfer(1, 1'b0, 9'h180, 8'h00, 0, 0,    1'b0, 8'h00, 2'b10, 8'h00, 1);
        xfer(1, 1'b0, 9'h100, 8'h00, 2, 1,    1'b0, 8'h7E, 2'b00, 8'h7E, 4);
        xfer(2, 1'b0, 9'h0AA, 8'h00, 0, 100,  1'b0, 8'h3C, 2'b00, 8'h3C, 103);
        // reset in the middle of a stalled read: bus drops at once, no response
        @(negedge PCLK);
        sl_d = 0; sl_idx = 0; sl_wait = 1000; sl_err = 1'b0;
        rv = 3'b001; rw = 1'b0; ra = 9'h010;
        @(posedge PCLK);
        #1 rv = '0;
        repeat (3) @(negedge PCLK);
        chk("pre_rst_access", 32'({psel0, pen[0]}), 32'b011);
        #1 PRESETn = 1'b0;
        #1;
        chk("midrst_bus", 32'({psel0, pen[0], pwr[0], pa[0], pw[0]}), 32'd0);
        chk("midrst_rsp", 32'({rspv[0], rd[0], st[0]}), 32'd0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(0, 1'b1, 9'h150, 8'hA5, 1, 0,    1'b0, 8'h00, 2'b00, 8'h00, 3);
        repeat (3) @(negedge PCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
